// File: rtl/vram_pkg.sv
// Shared constants, slot encoding and byte-lane helpers for the video RAM arbiter.
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;                     // 64 KB byte address space
    localparam int VRAM_PAGE_W = 3;                      // 8 pages
    localparam int WIN_W       = VRAM_ADDR_W - VRAM_PAGE_W; // CPU window offset width (8 KB)
    localparam int WORD_AW     = VRAM_ADDR_W - 1;        // 16-bit word address width

    // The slot owning the memory at a clk edge is simply the sampled cpu_clk level.
    typedef enum logic {
        SLOT_VGA = 1'b0,
        SLOT_CPU = 1'b1
    } slot_e;

    localparam logic LANE_LO = 1'b0;                     // byte in word[7:0]
    localparam logic LANE_HI = 1'b1;                     // byte in word[15:8]

    // Pick the addressed byte out of a 16-bit memory word.
    function automatic logic [7:0] lane_byte(input logic [15:0] word, input logic lane);
        return (lane == LANE_LO) ? word[7:0] : word[15:8];
    endfunction

    // Nibble write mask covering only the addressed byte lane.
    function automatic logic [3:0] lane_mask(input logic lane);
        return (lane == LANE_HI) ? 4'b1100 : 4'b0011;
    endfunction

    // Physical word address of a CPU window access. The page is concatenated,
    // never added, so offset 0x1FFF cannot carry into the page bits.
    function automatic logic [WORD_AW-1:0] cpu_word_addr(input logic [VRAM_PAGE_W-1:0] page,
                                                         input logic [WIN_W-1:0]       ofs);
        return {page, ofs[WIN_W-1:1]};
    endfunction

endpackage

// File: rtl/vram_spram.sv
// 32K x 16 single-port RAM with registered read and nibble write mask.
// Mirrors two SB_SPRAM256KA macros banked on word address bit 14: only the
// addressed bank is chip-selected, each bank keeps its own output register,
// and a write leaves the output register untouched.
module vram_spram
    import vram_pkg::*;
(
    input  logic               clk,
    input  logic [WORD_AW-1:0] addr,
    input  logic [15:0]        din,
    input  logic [3:0]         maskwren,
    input  logic               wren,
    output logic [15:0]        dout
);

    localparam int BANK_AW    = WORD_AW - 1;            // 14-bit address inside one macro
    localparam int BANK_DEPTH = 1 << BANK_AW;

    logic bank_q;
    logic bank_d;

    genvar b;
    generate
        for (b = 0; b < 2; b++) begin : g_bank
            logic [15:0] mem [0:BANK_DEPTH-1];
            logic [15:0] rdata_q;
            logic [15:0] rdata_d;
            logic        cs;

            assign cs = (addr[BANK_AW] == 1'(b));

            // Nibble-masked write into the selected bank; no reset, contents persist.
            always_ff @(posedge clk) begin
                if (cs && wren) begin
                    for (int n = 0; n < 4; n++) begin
                        if (maskwren[n]) begin
                            mem[addr[BANK_AW-1:0]][n*4 +: 4] <= din[n*4 +: 4];
                        end
                    end
                end
            end

            // Output register loads only on a read of this bank, otherwise holds.
            always_comb begin
                rdata_d = rdata_q;
                if (cs && !wren) begin
                    rdata_d = mem[addr[BANK_AW-1:0]];
                end
            end

            // Bank output register.
            always_ff @(posedge clk) begin
                rdata_q <= rdata_d;
            end
        end
    endgenerate

    // Remember which bank the last read came from so the output mux follows it.
    always_comb begin
        bank_d = bank_q;
        if (!wren) begin
            bank_d = addr[BANK_AW];
        end
    end

    // Bank-select register for the output mux.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign dout = bank_q ? g_bank[1].rdata_q : g_bank[0].rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: one SPRAM pair shared between the 6502 window and VGA DMA.
// Edges sampled with cpu_clk==0 belong to VGA, edges with cpu_clk==1 to the CPU,
// so neither side ever waits. Read data lands in the memory output register one
// edge after the address, and each side picks its byte lane from that register.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int    ADDR_W    = VRAM_ADDR_W,
    parameter int    PAGE_W    = VRAM_PAGE_W,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_clk,
    input  logic                     cpu_sel,
    input  logic                     cpu_we,
    input  logic [ADDR_W-PAGE_W-1:0] cpu_addr,
    input  logic [7:0]               cpu_dbw,
    output logic [7:0]               cpu_dbr,
    input  logic [PAGE_W-1:0]        vga_page,
    input  logic [ADDR_W-1:0]        vga_addr,
    output logic [7:0]               vga_data,
    output logic                     phase_err
);

    slot_e              slot;

    logic [WORD_AW-1:0] mem_addr;
    logic [15:0]        mem_din;
    logic [3:0]         mem_mask;
    logic               mem_wren;
    logic [15:0]        mem_dout;

    logic               vlane_q,     vlane_d;
    logic               rlane_q,     rlane_d;
    logic               cpu_rd_q,    cpu_rd_d;
    logic [7:0]         cpu_dbr_q,   cpu_dbr_d;
    logic               ph_q,        ph_d;
    logic               phase_err_q, phase_err_d;

    assign slot = slot_e'(cpu_clk);

    // Memory port mux: VGA address on V-edges, CPU window address on C-edges.
    // A CPU write is suppressed while rst is high so a reset cannot corrupt RAM.
    always_comb begin
        mem_addr = vga_addr[ADDR_W-1:1];
        mem_din  = {cpu_dbw, cpu_dbw};
        mem_mask = 4'b0000;
        mem_wren = 1'b0;
        if (slot == SLOT_CPU) begin
            mem_addr = cpu_word_addr(vga_page, cpu_addr);
            if (cpu_sel && cpu_we && !rst) begin
                mem_wren = 1'b1;
                mem_mask = lane_mask(cpu_addr[0]);
            end
        end
    end

    vram_spram u_spram (
        .clk      (clk),
        .addr     (mem_addr),
        .din      (mem_din),
        .maskwren (mem_mask),
        .wren     (mem_wren),
        .dout     (mem_dout)
    );

    // Next-state for lane tracking, CPU read capture and the phase checker.
    always_comb begin
        vlane_d     = vlane_q;
        rlane_d     = rlane_q;
        cpu_rd_d    = cpu_rd_q;
        cpu_dbr_d   = cpu_dbr_q;
        ph_d        = cpu_clk;
        phase_err_d = phase_err_q | (cpu_clk == ph_q);

        if (slot == SLOT_VGA) begin
            vlane_d = vga_addr[0];
            // The memory register still holds the CPU read from the last C-edge.
            if (cpu_rd_q) begin
                cpu_dbr_d = lane_byte(mem_dout, rlane_q);
            end
        end else begin
            rlane_d  = cpu_addr[0];
            cpu_rd_d = cpu_sel && !cpu_we;
        end
    end

    // State registers with asynchronous reset; RAM contents are never cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vlane_q     <= LANE_LO;
            rlane_q     <= LANE_LO;
            cpu_rd_q    <= 1'b0;
            cpu_dbr_q   <= 8'h00;
            ph_q        <= 1'b1;
            phase_err_q <= 1'b0;
        end else begin
            vlane_q     <= vlane_d;
            rlane_q     <= rlane_d;
            cpu_rd_q    <= cpu_rd_d;
            cpu_dbr_q   <= cpu_dbr_d;
            ph_q        <= ph_d;
            phase_err_q <= phase_err_d;
        end
    end

    // VGA data is only meaningful between a V-edge and the following C-edge.
    assign vga_data  = lane_byte(mem_dout, vlane_q);
    assign cpu_dbr   = cpu_dbr_q;
    assign phase_err = phase_err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table of CPU-cycle vectors plus
// hand-written sequences for reset, window wrap and phase errors.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_clk = 1'b0;
    logic        cpu_sel = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_dbw = '0;
    logic [7:0]  cpu_dbr;
    logic [2:0]  vga_page = '0;
    logic [15:0] vga_addr = '0;
    logic [7:0]  vga_data;
    logic        phase_err;

    vram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_clk   (cpu_clk),
        .cpu_sel   (cpu_sel),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_dbw   (cpu_dbw),
        .cpu_dbr   (cpu_dbr),
        .vga_page  (vga_page),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .phase_err (phase_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] vaddr;
        logic        vchk;
        logic [7:0]  vexp;
        logic        sel;
        logic        we;
        logic [2:0]  page;
        logic [12:0] addr;
        logic [7:0]  dbw;
        logic [7:0]  cexp;
    } vec_t;

    vec_t        vecs [13];
    logic [7:0]  ref_mem [int];
    logic [7:0]  vga_sb [$];
    logic [7:0]  cpu_sb [$];
    logic [7:0]  model_dbr = 8'h00;
    logic        exp_err = 1'b0;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // One CPU cycle: V-edge (VGA read of vaddr) then C-edge (CPU access).
    // A CPU read pushes its expected byte; it is popped after the next V-edge.
    task automatic run_cycle(input logic [15:0] vaddr, input logic vchk, input logic [7:0] vexp,
                             input logic sel, input logic we, input logic [2:0] page,
                             input logic [12:0] addr, input logic [7:0] dbw, input logic [7:0] cexp);
        cpu_clk  = 1'b0;
        vga_addr = vaddr;
        cpu_sel  = 1'b0;
        cpu_we   = 1'b0;
        if (vchk) vga_sb.push_back(vexp);
        @(posedge clk); #1;
        if (cpu_sb.size() > 0) model_dbr = cpu_sb.pop_front();
        check8("cpu_dbr", cpu_dbr, model_dbr);
        if (vga_sb.size() > 0) check8("vga_data", vga_data, vga_sb.pop_front());

        cpu_clk  = 1'b1;
        cpu_sel  = sel;
        cpu_we   = we;
        vga_page = page;
        cpu_addr = addr;
        cpu_dbw  = dbw;
        if (sel && !we) cpu_sb.push_back(cexp);
        if (sel && we) ref_mem[int'({page, addr})] = dbw;
        @(posedge clk); #1;
        check8("cpu_dbr_hold", cpu_dbr, model_dbr);
        check1("phase_err", phase_err, exp_err);
    endtask

    // Same as run_cycle but expectations come from the reference memory.
    task automatic ref_cycle(input logic [15:0] vaddr, input logic sel, input logic we,
                             input logic [2:0] page, input logic [12:0] addr, input logic [7:0] dbw);
        logic       vchk;
        logic [7:0] vexp;
        logic [7:0] cexp;
        int         pa;
        vchk = ref_mem.exists(int'(vaddr));
        vexp = vchk ? ref_mem[int'(vaddr)] : 8'h00;
        pa   = int'({page, addr});
        cexp = ref_mem.exists(pa) ? ref_mem[pa] : 8'h00;
        run_cycle(vaddr, vchk, vexp, sel, we, page, addr, dbw, cexp);
    endtask

    // Hold rst for 4 clk with cpu_clk toggling; optionally attempt a write of 0xAA @0x0000.
    task automatic do_reset(input logic with_wr);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_clk  = (i % 2 == 1);
            cpu_sel  = with_wr && (i % 2 == 1);
            cpu_we   = with_wr && (i % 2 == 1);
            cpu_dbw  = 8'hAA;
            vga_page = 3'd0;
            cpu_addr = 13'h0000;
            @(posedge clk); #1;
        end
        check8("reset_cpu_dbr", cpu_dbr, 8'h00);
        check1("reset_phase_err", phase_err, 1'b0);
        cpu_clk   = 1'b0;
        cpu_sel   = 1'b0;
        cpu_we    = 1'b0;
        rst       = 1'b0;
        model_dbr = 8'h00;
        exp_err   = 1'b0;
        cpu_sb.delete();
        vga_sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // vaddr, vchk, vexp, sel, we, page, addr, dbw, cexp
        vecs[0]  = '{16'h0000, 1'b1, 8'h77, 1'b1, 1'b1, 3'd2, 13'h0000, 8'h11, 8'h00};
        vecs[1]  = '{16'h0000, 1'b1, 8'h77, 1'b1, 1'b1, 3'd2, 13'h0001, 8'h5A, 8'h00};
        vecs[2]  = '{16'h4001, 1'b1, 8'h5A, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00, 8'h00};
        vecs[3]  = '{16'h4000, 1'b1, 8'h11, 1'b1, 1'b0, 3'd2, 13'h0001, 8'h00, 8'h5A};
        vecs[4]  = '{16'h4001, 1'b1, 8'h5A, 1'b1, 1'b1, 3'd4, 13'h0000, 8'h34, 8'h00};
        vecs[5]  = '{16'h8000, 1'b1, 8'h34, 1'b1, 1'b1, 3'd4, 13'h0001, 8'h12, 8'h00};
        vecs[6]  = '{16'h8000, 1'b1, 8'h34, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00, 8'h00};
        vecs[7]  = '{16'h8001, 1'b1, 8'h12, 1'b1, 1'b0, 3'd4, 13'h0000, 8'h00, 8'h34};
        vecs[8]  = '{16'h8000, 1'b1, 8'h34, 1'b1, 1'b1, 3'd4, 13'h0001, 8'h56, 8'h00};
        vecs[9]  = '{16'h8001, 1'b1, 8'h56, 1'b1, 1'b0, 3'd4, 13'h0000, 8'h00, 8'h34};
        vecs[10] = '{16'h4000, 1'b1, 8'h11, 1'b1, 1'b1, 3'd1, 13'h0ABC, 8'hC3, 8'h00};
        vecs[11] = '{16'h2ABC, 1'b1, 8'hC3, 1'b1, 1'b0, 3'd1, 13'h0ABC, 8'h00, 8'hC3};
        vecs[12] = '{16'h8001, 1'b1, 8'h56, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00, 8'h00};

        #2;
        // Reset values, then a write attempted under reset must not land.
        do_reset(1'b0);
        ref_cycle(16'h0000, 1'b1, 1'b1, 3'd0, 13'h0000, 8'h77);
        ref_cycle(16'h0000, 1'b1, 1'b0, 3'd0, 13'h0000, 8'h00);
        ref_cycle(16'h0000, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00);
        do_reset(1'b1);
        ref_cycle(16'h0000, 1'b1, 1'b0, 3'd0, 13'h0000, 8'h00);
        ref_cycle(16'h0000, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00);

        // Paged write/VGA read, lane selection, latency and write-then-read.
        for (int i = 0; i < 13; i++) begin
            run_cycle(vecs[i].vaddr, vecs[i].vchk, vecs[i].vexp, vecs[i].sel, vecs[i].we,
                      vecs[i].page, vecs[i].addr, vecs[i].dbw, vecs[i].cexp);
            if (vecs[i].sel && vecs[i].we)
                ref_mem[int'({vecs[i].page, vecs[i].addr})] = vecs[i].dbw;
        end

        // Window wrap: CPU reads top of page 7 while VGA streams from 0x0000.
        for (int i = 0; i < 8; i++)
            ref_cycle(16'(i), 1'b1, 1'b1, 3'd0, 13'(i), 8'(i * 37 + 5));
        ref_cycle(16'h0000, 1'b1, 1'b1, 3'd7, 13'h1FFF, 8'hE7);
        ref_cycle(16'h0001, 1'b1, 1'b1, 3'd7, 13'h1FFE, 8'h3C);
        for (int i = 0; i < 8; i++)
            ref_cycle(16'(i), (i % 2 == 0), 1'b0, 3'd7,
                      (i % 4 == 0) ? 13'h1FFF : 13'h1FFE, 8'h00);
        ref_cycle(16'hFFFF, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00);

        // Phase checker: cpu_clk stuck high for 2 clk sets a sticky error.
        cpu_clk = 1'b1;
        cpu_sel = 1'b0;
        cpu_we  = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        exp_err = 1'b1;
        check1("phase_err_set", phase_err, 1'b1);
        ref_cycle(16'h0003, 1'b1, 1'b0, 3'd7, 13'h1FFE, 8'h00);
        ref_cycle(16'hFFFE, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00);
        ref_cycle(16'h0005, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00);
        do_reset(1'b0);
        ref_cycle(16'hFFFF, 1'b1, 1'b0, 3'd7, 13'h1FFF, 8'h00);
        ref_cycle(16'h0002, 1'b0, 1'b0, 3'd0, 13'h0000, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
